dmem_store_ctrl: RTL and testbench

- Store-queue and arbitration controller for the single-port data memory.
- Accepts pipeline stores (address, raw rs2 data, StoreSel) and loads. Buffers stores in a small FIFO. Generates the lane-shifted write data and byte-enable mask.
- Grants the dmem port to one access per cycle, with load priority, RAW hazard blocking and a drain (fence) sequence.

---
 rtl/dmem_store_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_dmem_store_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_ctrl.sv
// Store queue and single-port dmem arbiter: load priority, RAW blocking, drain.
// Optional perf counters under `define DMEM_STORE_PERF_EN.
module dmem_store_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_sel,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic        drain_req,
  output logic        drain_done,
  output logic        misalign_err,
  output logic        dmem_en,
  output logic [3:0]  dmem_we,
  output logic [29:0] dmem_addr,
  output logic [31:0] dmem_wdata
`ifdef DMEM_STORE_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_st_issued,
  output logic [CNT_W-1:0] perf_ld_stall
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [0:0] NORMAL = 1'b0;
  localparam logic [0:0] DRAIN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [DEPTH-1:0] vld_q;

  logic [29:0] addr_q [DEPTH];
  logic [3:0]  be_q   [DEPTH];
  logic [31:0] wd_q   [DEPTH];

  logic        en_q;
  logic [3:0]  we_q;
  logic [29:0] dadr_q;
  logic [31:0] dwd_q;
  logic        done_q, done_d;
  logic        err_q;

  logic        legal;
  logic [3:0]  f_we;
  logic [31:0] f_wd;
  logic [1:0]  off;
  logic        hazard;
  logic        full;
  logic        st_go;
  logic        st_acc;
  logic        enq;

  assign off = st_addr[1:0];

  always_comb begin
    legal = 1'b0;
    f_we  = 4'b0000;
    f_wd  = 32'h0;
    unique case (st_sel)
      2'b00: begin
        legal = 1'b1;
        f_we  = 4'b0001 << off;
        f_wd  = {24'h0, st_data[7:0]} << {off, 3'b000};
      end
      2'b01: begin
        legal = !off[0];
        f_we  = off[1] ? 4'b1100 : 4'b0011;
        f_wd  = {16'h0, st_data[15:0]} << {off, 3'b000};
      end
      2'b10: begin
        legal = (off == 2'b00);
        f_we  = 4'b1111;
        f_wd  = st_data;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && addr_q[i] == ld_addr[31:2]) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard && ld_valid;
  end

  assign full     = (cnt_q == FULL);
  assign st_ready = !full && (state_q == NORMAL);
  assign st_go    = (cnt_q != '0) &&
                    ((state_q == DRAIN) || full ||
                     hazard || !ld_valid);
  assign ld_ready = ld_valid && (state_q == NORMAL)
                    && !st_go;
  assign st_acc   = st_valid && st_ready;
  assign enq      = st_acc && legal;

  always_comb begin
    cnt_d  = cnt_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (enq) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (st_go) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({enq, st_go})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Drain completes in the cycle the last entry leaves (or at once if empty).
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      NORMAL: begin
        if (drain_req) begin
          state_d = DRAIN;
        end
      end
      default: begin
        if (cnt_d == '0) begin
          state_d = NORMAL;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      vld_q   <= '0;
      en_q    <= 1'b0;
      we_q    <= 4'b0000;
      dadr_q  <= 30'h0;
      dwd_q   <= 32'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      done_q  <= done_d;
      err_q   <= st_acc && !legal;
      if (st_go) begin
        vld_q[rptr_q] <= 1'b0;
      end
      if (enq) begin
        vld_q[wptr_q] <= 1'b1;
      end
      if (st_go) begin
        en_q   <= 1'b1;
        we_q   <= be_q[rptr_q];
        dadr_q <= addr_q[rptr_q];
        dwd_q  <= wd_q[rptr_q];
      end else if (ld_ready) begin
        en_q   <= 1'b1;
        we_q   <= 4'b0000;
        dadr_q <= ld_addr[31:2];
        dwd_q  <= 32'h0;
      end else begin
        en_q   <= 1'b0;
        we_q   <= 4'b0000;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wptr_q] <= st_addr[31:2];
      be_q[wptr_q]   <= f_we;
      wd_q[wptr_q]   <= f_wd;
    end
  end

  assign drain_done   = done_q;
  assign misalign_err = err_q;
  assign dmem_en      = en_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = dadr_q;
  assign dmem_wdata   = dwd_q;

`ifdef DMEM_STORE_PERF_EN
  logic [CNT_W-1:0] pst_q;
  logic [CNT_W-1:0] pld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pst_q <= '0;
      pld_q <= '0;
    end else begin
      if (st_go) begin
        pst_q <= pst_q + 1'b1;
      end
      if (ld_valid && !ld_ready) begin
        pld_q <= pld_q + 1'b1;
      end
    end
  end

  assign perf_st_issued = pst_q;
  assign perf_ld_stall  = pld_q;
`endif

endmodule

// File: tb/tb_dmem_store_ctrl.sv
// Directed bench for dmem_store_ctrl with a queue-based reference model.
// Checks every cycle plus hand-computed literals at key points.
module tb_dmem_store_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic [1:0]  st_sel = 2'b00;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_addr = 32'h0;
  logic        drain_req = 1'b0;
  logic        drain_done;
  logic        misalign_err;
  logic        dmem_en;
  logic [3:0]  dmem_we;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata;
`ifdef DMEM_STORE_PERF_EN
  logic [31:0] perf_st_issued;
  logic [31:0] perf_ld_stall;
`endif

  dmem_store_ctrl #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data),
    .st_sel(st_sel),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr),
    .drain_req(drain_req), .drain_done(drain_done),
    .misalign_err(misalign_err),
    .dmem_en(dmem_en), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata)
`ifdef DMEM_STORE_PERF_EN
    ,
    .perf_st_issued(perf_st_issued),
    .perf_ld_stall(perf_ld_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;

  typedef struct packed {
    logic [29:0] wa;
    logic [3:0]  be;
    logic [31:0] wd;
  } ent_t;

  ent_t q[$];
  bit          mdrain = 1'b0;
  logic        e_en = 1'b0;
  logic [3:0]  e_we = 4'h0;
  logic [29:0] e_addr = 30'h0;
  logic [31:0] e_wd = 32'h0;
  logic        e_done = 1'b0;
  logic        e_err = 1'b0;
  int unsigned m_pst = 0;
  int unsigned m_pld = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Byte lane b carries source byte (b - off) for the access size.
  function automatic void fmt(input logic [31:0] a,
                              input logic [31:0] d,
                              input logic [1:0] sel,
                              output bit ok,
                              output ent_t e);
    int sz;
    int off;
    sz = (sel == 2'd0) ? 1 : (sel == 2'd1) ? 2 : 4;
    off = int'(a % 4);
    ok = (sel != 2'd3) && (off % sz == 0);
    e.wa = a[31:2];
    e.be = 4'h0;
    e.wd = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (b >= off && b < off + sz) begin
        e.be[b] = 1'b1;
        e.wd[8*b +: 8] = d[8*(b-off) +: 8];
      end
    end
  endfunction

  function automatic void arb(output bit go,
                              output bit ldr,
                              output bit sr);
    bit hz;
    bit full;
    hz = 1'b0;
    full = (q.size() == DEPTH);
    foreach (q[i]) begin
      if (ld_valid && q[i].wa == ld_addr[31:2]) hz = 1'b1;
    end
    sr = !full && !mdrain;
    go = (q.size() > 0) && (mdrain || full || hz || !ld_valid);
    ldr = ld_valid && !mdrain && !go;
  endfunction

  always @(posedge clk) begin
    bit go, ldr, sr, ok;
    ent_t e;
    if (rst) begin
      q.delete();
      mdrain = 1'b0;
      e_en = 1'b0; e_we = 4'h0; e_addr = 30'h0; e_wd = 32'h0;
      e_done = 1'b0; e_err = 1'b0;
      m_pst = 0; m_pld = 0;
    end else begin
      arb(go, ldr, sr);
      fmt(st_addr, st_data, st_sel, ok, e);
      e_err = st_valid && sr && !ok;
      if (ld_valid && !ldr) m_pld++;
      if (go) begin
        m_pst++;
        e_en = 1'b1; e_we = q[0].be;
        e_addr = q[0].wa; e_wd = q[0].wd;
        void'(q.pop_front());
      end else if (ldr) begin
        e_en = 1'b1; e_we = 4'h0;
        e_addr = ld_addr[31:2];
      end else begin
        e_en = 1'b0; e_we = 4'h0;
      end
      if (st_valid && sr && ok) q.push_back(e);
      e_done = 1'b0;
      if (mdrain && q.size() == 0) begin
        mdrain = 1'b0;
        e_done = 1'b1;
      end else if (!mdrain && drain_req) begin
        mdrain = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    bit go, ldr, sr;
    if (mon_on && !rst) begin
      arb(go, ldr, sr);
      chk("st_ready", st_ready, sr);
      chk("ld_ready", ld_ready, ldr);
      chk("dmem_en", dmem_en, e_en);
      chk("dmem_we", dmem_we, e_we);
      if (e_en) chk("dmem_addr", dmem_addr, e_addr);
      if (e_en && e_we != 4'h0) chk("dmem_wdata", dmem_wdata, e_wd);
      chk("drain_done", drain_done, e_done);
      chk("misalign_err", misalign_err, e_err);
`ifdef DMEM_STORE_PERF_EN
      chk("perf_st", perf_st_issued, m_pst);
      chk("perf_ld", perf_ld_stall, m_pld);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [1:0] s);
    st_valid = 1'b1;
    st_addr = a;
    st_data = d;
    st_sel = s;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_en", dmem_en, 1'b0);
    chk("rst_we", dmem_we, 4'h0);
    chk("rst_addr", dmem_addr, 30'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_done", drain_done, 1'b0);
    chk("rst_err", misalign_err, 1'b0);
    chk("rst_st_ready", st_ready, 1'b1);
    tick();

    st(32'h1003, 32'h12345678, 2'd0);
    tick();
    st_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("sb_we", dmem_we, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'h78000000);
    chk("sb_addr", dmem_addr, 30'h400);
    tick();

    st(32'h2002, 32'hAABBCCDD, 2'd1);
    tick();
    st_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("sh_we", dmem_we, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hCCDD0000);
    chk("sh_addr", dmem_addr, 30'h800);
    tick();

    st(32'h2001, 32'h11111111, 2'd2);
    @(negedge clk);
    chk("sw_mis_ready", st_ready, 1'b1);
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    chk("sw_mis_err", misalign_err, 1'b1);
    tick();
    @(negedge clk);
    chk("sw_mis_nowrite", dmem_en, 1'b0);
    chk("sw_mis_errpulse", misalign_err, 1'b0);
    tick();

    ld_valid = 1'b1;
    ld_addr = 32'h3000;
    for (int i = 0; i < 4; i++) begin
      st(32'h4000 + 32'(4*i), 32'hA0 + 32'(i), 2'd2);
      @(negedge clk);
      chk("fill_ld_grant", ld_ready, 1'b1);
      tick();
    end
    st_valid = 1'b0;
    @(negedge clk);
    chk("full_st_ready", st_ready, 1'b0);
    chk("full_ld_ready", ld_ready, 1'b0);
    tick();
    @(negedge clk);
    chk("full_ld_regrant", ld_ready, 1'b1);
    chk("full_st_addr", dmem_addr, 30'h1000);
    chk("full_st_we", dmem_we, 4'hF);
    tick(); tick();
    ld_valid = 1'b0;
    repeat (4) tick();

    st(32'h5004, 32'hDEADBEEF, 2'd2);
    tick();
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr = 32'h5006;
    @(negedge clk);
    chk("raw_block", ld_ready, 1'b0);
    tick();
    @(negedge clk);
    chk("raw_release", ld_ready, 1'b1);
    chk("raw_st_addr", dmem_addr, 30'h1401);
    chk("raw_st_we", dmem_we, 4'hF);
    tick();
    @(negedge clk);
    chk("raw_ld_en", dmem_en, 1'b1);
    chk("raw_ld_addr", dmem_addr, 30'h1401);
    chk("raw_ld_we", dmem_we, 4'h0);
    ld_valid = 1'b0;
    tick();

    ld_valid = 1'b1;
    ld_addr = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      st(32'h6000 + 32'(4*i), 32'hC0 + 32'(i), 2'd2);
      tick();
    end
    st_valid = 1'b0;
    drain_req = 1'b1;
    @(negedge clk);
    chk("drn_last_ld", ld_ready, 1'b1);
    tick();
    drain_req = 1'b0;
    @(negedge clk);
    chk("drn_st_ready", st_ready, 1'b0);
    chk("drn_ld_ready", ld_ready, 1'b0);
    tick();
    @(negedge clk);
    chk("drn_w0", dmem_addr, 30'h1800);
    tick();
    @(negedge clk);
    chk("drn_w1", dmem_addr, 30'h1801);
    chk("drn_early", drain_done, 1'b0);
    tick();
    @(negedge clk);
    chk("drn_w2", dmem_addr, 30'h1802);
    chk("drn_w2_en", dmem_en, 1'b1);
    chk("drn_done", drain_done, 1'b1);
    tick();
    @(negedge clk);
    chk("drn_done_pulse", drain_done, 1'b0);
    chk("drn_normal", st_ready, 1'b1);
    ld_valid = 1'b0;
    tick();

    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    @(negedge clk);
    chk("edrn_st_ready", st_ready, 1'b0);
    tick();
    @(negedge clk);
    chk("edrn_done", drain_done, 1'b1);
    tick();

    ld_valid = 1'b1;
    ld_addr = 32'h3000;
    st(32'h7000, 32'h55, 2'd2);
    tick();
    st(32'h7004, 32'h66, 2'd0);
    drain_req = 1'b1;
    tick();
    st_valid = 1'b0;
    drain_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ld_addr = 32'h7000;
    @(negedge clk);
    chk("rstd_en", dmem_en, 1'b0);
    chk("rstd_st_ready", st_ready, 1'b1);
    chk("rstd_no_hazard", ld_ready, 1'b1);
    tick();
    ld_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstd_no_write", dmem_en, 1'b0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
